// File: rtl/ibf_cfg_write_loader.sv
// rtl/ibf_cfg_write_loader.sv - splits config commands into paced 64-bit write beats for the IBF config SRAM bank
module ibf_cfg_write_loader #(
    parameter int NUM_SRAM  = 16,
    parameter int MAX_WORDS = 4,
    parameter int WR_GAP    = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_sel,
    input  logic [2:0]  cmd_nwords,
    input  logic        abort,
    input  logic        dat_valid,
    output logic        dat_ready,
    input  logic [63:0] dat_data,
    output logic [3:0]  sram_sel,
    output logic [1:0]  wr_addr,
    output logic        wr_en,
    output logic [63:0] din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Widened so that a select equal to 16 is still representable in the compare.
    localparam logic [4:0] NUM_SRAM_W = 5'(NUM_SRAM);
    localparam logic [2:0] MAX_WORDS_W = 3'(MAX_WORDS);
    // Last gap-counter value before returning to DATA; unused when WR_GAP is 0.
    localparam logic [3:0] GAP_LAST = 4'(WR_GAP - 1);

    state_t      state;
    logic [3:0]  sel_q;
    logic [2:0]  nwords_q;
    logic [2:0]  cnt;
    logic [3:0]  gap_cnt;
    logic        cmd_bad;

    // Command legality: non-empty, within the per-entry word limit, and a real SRAM target.
    assign cmd_bad = (cmd_nwords == 3'd0) ||
                     (cmd_nwords > MAX_WORDS_W) ||
                     ({1'b0, cmd_sel} >= NUM_SRAM_W);

    // Handshake signals follow the state directly; cmd_ready is held low while in reset.
    assign cmd_ready = (state == IDLE) && !rst;
    assign dat_ready = (state == DATA) && !abort;
    assign busy      = (state != IDLE);

    // Burst sequencer: validates commands, issues one registered write per accepted beat, paces with GAP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel_q    <= 4'd0;
            nwords_q <= 3'd0;
            cnt      <= 3'd0;
            gap_cnt  <= 4'd0;
            sram_sel <= 4'd0;
            wr_addr  <= 2'd0;
            wr_en    <= 1'b0;
            din      <= 64'd0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            sel_q    <= cmd_sel;
                            nwords_q <= cmd_nwords;
                            cnt      <= 3'd0;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (dat_valid) begin
                        wr_en    <= 1'b1;
                        din      <= dat_data;
                        wr_addr  <= cnt[1:0];
                        sram_sel <= sel_q;
                        cnt      <= cnt + 3'd1;
                        if (cnt == nwords_q - 3'd1) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (WR_GAP > 0) begin
                            gap_cnt <= 4'd0;
                            state   <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= DATA;
                    end else begin
                        gap_cnt <= gap_cnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ibf_cfg_write_loader.sv
// tb/tb_ibf_cfg_write_loader.sv - checks two loader instances (WR_GAP 0 / NUM_SRAM 8 and WR_GAP 2 / NUM_SRAM 16)
module tb_ibf_cfg_write_loader;

    localparam int GAP1 = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid  [2];
    logic        cmd_ready  [2];
    logic [3:0]  cmd_sel    [2];
    logic [2:0]  cmd_nwords [2];
    logic        abort      [2];
    logic        dat_valid  [2];
    logic        dat_ready  [2];
    logic [63:0] dat_data   [2];
    logic [3:0]  sram_sel   [2];
    logic [1:0]  wr_addr    [2];
    logic        wr_en      [2];
    logic [63:0] din        [2];
    logic        busy       [2];
    logic        done       [2];
    logic        err        [2];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state per instance, expressed as "next cycle" expectations.
    bit          m_burst    [2];
    bit          m_donep    [2];
    bit          m_wr       [2];
    bit          m_done     [2];
    bit          m_err      [2];
    logic [3:0]  m_sel      [2];
    logic [1:0]  m_addr     [2];
    logic [63:0] m_din      [2];
    int          m_cur_sel  [2];
    int          m_idx      [2];
    int          m_n        [2];
    int          m_ready_at [2];
    int          wr_cnt     [2];
    int          done_cnt   [2];
    int          err_cnt    [2];
    int          last_wr    [2];
    int          min_gap    [2];

    typedef struct {
        int         d;
        logic [3:0] sel;
        logic [2:0] n;
        int         exp_wr;
        int         exp_done;
        int         exp_err;
    } vec_t;

    vec_t tbl [9];

    ibf_cfg_write_loader #(.NUM_SRAM(8), .MAX_WORDS(4), .WR_GAP(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_sel(cmd_sel[0]), .cmd_nwords(cmd_nwords[0]),
        .abort(abort[0]), .dat_valid(dat_valid[0]), .dat_ready(dat_ready[0]), .dat_data(dat_data[0]),
        .sram_sel(sram_sel[0]), .wr_addr(wr_addr[0]), .wr_en(wr_en[0]), .din(din[0]),
        .busy(busy[0]), .done(done[0]), .err(err[0])
    );

    ibf_cfg_write_loader #(.NUM_SRAM(16), .MAX_WORDS(4), .WR_GAP(GAP1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_sel(cmd_sel[1]), .cmd_nwords(cmd_nwords[1]),
        .abort(abort[1]), .dat_valid(dat_valid[1]), .dat_ready(dat_ready[1]), .dat_data(dat_data[1]),
        .sram_sel(sram_sel[1]), .wr_addr(wr_addr[1]), .wr_en(wr_en[1]), .din(din[1]),
        .busy(busy[1]), .done(done[1]), .err(err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : GAP1;
    endfunction

    function automatic int nsram_of(input int d);
        return (d == 0) ? 8 : 16;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        m_burst[d] = 0; m_donep[d] = 0; m_wr[d] = 0; m_done[d] = 0; m_err[d] = 0;
        m_sel[d] = 4'd0; m_addr[d] = 2'd0; m_din[d] = 64'd0;
        m_idx[d] = 0; m_n[d] = 0; m_ready_at[d] = 0;
    endtask

    // Compares every output each cycle against the model, then advances the model on the sampled inputs.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                bit idle;
                bit exp_dr;
                if (rst) model_reset(d);
                idle   = !m_burst[d] && !m_donep[d];
                exp_dr = m_burst[d] && (cyc >= m_ready_at[d]) && !abort[d];
                chk($sformatf("d%0d cmd_ready", d), 64'(cmd_ready[d]), 64'(idle && !rst));
                chk($sformatf("d%0d busy", d),      64'(busy[d]),      64'(!idle));
                chk($sformatf("d%0d dat_ready", d), 64'(dat_ready[d]), 64'(exp_dr));
                chk($sformatf("d%0d wr_en", d),     64'(wr_en[d]),     64'(m_wr[d]));
                chk($sformatf("d%0d sram_sel", d),  64'(sram_sel[d]),  64'(m_sel[d]));
                chk($sformatf("d%0d wr_addr", d),   64'(wr_addr[d]),   64'(m_addr[d]));
                chk($sformatf("d%0d din", d),       din[d],            m_din[d]);
                chk($sformatf("d%0d done", d),      64'(done[d]),      64'(m_done[d]));
                chk($sformatf("d%0d err", d),       64'(err[d]),       64'(m_err[d]));
                if (wr_en[d]) begin
                    wr_cnt[d]++;
                    if (wr_addr[d] != 2'd0 && (cyc - last_wr[d]) < min_gap[d]) min_gap[d] = cyc - last_wr[d];
                    last_wr[d] = cyc;
                end
                if (done[d]) done_cnt[d]++;
                if (err[d]) err_cnt[d]++;
                if (!rst) begin
                    m_wr[d] = 0; m_done[d] = 0; m_err[d] = 0;
                    if (m_donep[d]) begin
                        m_donep[d] = 0;
                    end else if (m_burst[d]) begin
                        if (abort[d]) begin
                            m_burst[d] = 0;
                            m_err[d]   = 1;
                        end else if (exp_dr && dat_valid[d]) begin
                            m_wr[d]   = 1;
                            m_sel[d]  = 4'(m_cur_sel[d]);
                            m_addr[d] = 2'(m_idx[d]);
                            m_din[d]  = dat_data[d];
                            m_idx[d]++;
                            if (m_idx[d] == m_n[d]) begin
                                m_burst[d] = 0;
                                m_donep[d] = 1;
                                m_done[d]  = 1;
                            end else begin
                                m_ready_at[d] = cyc + 1 + gap_of(d);
                            end
                        end
                    end else if (cmd_valid[d]) begin
                        if (int'(cmd_nwords[d]) == 0 || int'(cmd_nwords[d]) > 4 || int'(cmd_sel[d]) >= nsram_of(d)) begin
                            m_err[d] = 1;
                        end else begin
                            m_burst[d]    = 1;
                            m_cur_sel[d]  = int'(cmd_sel[d]);
                            m_n[d]        = int'(cmd_nwords[d]);
                            m_idx[d]      = 0;
                            m_ready_at[d] = cyc + 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic issue_cmd(input int d, input logic [3:0] s, input logic [2:0] n);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        cmd_valid[d] = 1'b1; cmd_sel[d] = s; cmd_nwords[d] = n;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready[d];
        end
        chk($sformatf("d%0d cmd_accepted", d), 64'(ok), 64'(1));
        @(posedge clk); #1;
        cmd_valid[d] = 1'b0;
    endtask

    task automatic send_beats(input int d, input int n, input logic [63:0] base, input bit toggle);
        for (int i = 0; i < n; i++) begin
            bit ok;
            ok = 0;
            if (toggle && ($urandom_range(0, 1) == 1)) begin
                dat_valid[d] = 1'b0;
                @(posedge clk); #1;
            end
            dat_valid[d] = 1'b1;
            dat_data[d]  = base + 64'(i);
            for (int k = 0; k < 50 && !ok; k++) begin
                @(negedge clk);
                ok = dat_ready[d];
            end
            chk($sformatf("d%0d beat_accepted", d), 64'(ok), 64'(1));
            @(posedge clk); #1;
            dat_valid[d] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0; cmd_sel[d] = 4'd0; cmd_nwords[d] = 3'd0;
            abort[d] = 1'b0; dat_valid[d] = 1'b0; dat_data[d] = 64'd0;
        end
    endtask

    initial begin
        int w0, d0, e0;
        rst = 1'b1;
        idle_inputs();
        for (int d = 0; d < 2; d++) begin
            model_reset(d);
            wr_cnt[d] = 0; done_cnt[d] = 0; err_cnt[d] = 0; last_wr[d] = 0; min_gap[d] = 1000;
        end
        fork
            monitor();
        join_none

        tbl[0] = '{0, 4'd3,  3'd4, 4, 1, 0};
        tbl[1] = '{0, 4'd1,  3'd0, 0, 0, 1};
        tbl[2] = '{0, 4'd1,  3'd5, 0, 0, 1};
        tbl[3] = '{0, 4'd15, 3'd2, 0, 0, 1};
        tbl[4] = '{0, 4'd8,  3'd1, 0, 0, 1};
        tbl[5] = '{0, 4'd7,  3'd1, 1, 1, 0};
        tbl[6] = '{0, 4'd0,  3'd7, 0, 0, 1};
        tbl[7] = '{1, 4'd15, 3'd4, 4, 1, 0};
        tbl[8] = '{1, 4'd9,  3'd2, 2, 1, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd_ready", 64'(cmd_ready[0]), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset cmd_ready", 64'(cmd_ready[0]), 64'(1));
        chk("post-reset busy", 64'(busy[1]), 64'(0));

        // Table of single commands with their expected write/done/err totals.
        for (int i = 0; i < 9; i++) begin
            int d;
            d  = tbl[i].d;
            w0 = wr_cnt[d]; d0 = done_cnt[d]; e0 = err_cnt[d];
            issue_cmd(d, tbl[i].sel, tbl[i].n);
            if (tbl[i].exp_wr > 0) send_beats(d, tbl[i].exp_wr, 64'hA0, 1'b0);
            repeat (4) @(posedge clk);
            #1;
            chk($sformatf("vec%0d writes", i), 64'(wr_cnt[d] - w0),   64'(tbl[i].exp_wr));
            chk($sformatf("vec%0d done", i),   64'(done_cnt[d] - d0), 64'(tbl[i].exp_done));
            chk($sformatf("vec%0d err", i),    64'(err_cnt[d] - e0),  64'(tbl[i].exp_err));
        end

        // Reset in the middle of a burst, then a fresh command.
        w0 = wr_cnt[0]; d0 = done_cnt[0]; e0 = err_cnt[0];
        issue_cmd(0, 4'd2, 3'd4);
        send_beats(0, 2, 64'hC0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("async rst wr_en", 64'(wr_en[0]), 64'(0));
        chk("async rst sram_sel", 64'(sram_sel[0]), 64'(0));
        chk("async rst din", din[0], 64'd0);
        chk("async rst busy", 64'(busy[0]), 64'(0));
        chk("async rst cmd_ready", 64'(cmd_ready[0]), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst-burst writes", 64'(wr_cnt[0] - w0), 64'(2));
        chk("rst-burst done", 64'(done_cnt[0] - d0), 64'(0));
        chk("rst-burst err", 64'(err_cnt[0] - e0), 64'(0));
        w0 = wr_cnt[0]; d0 = done_cnt[0];
        issue_cmd(0, 4'd6, 3'd2);
        send_beats(0, 2, 64'hE0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("post-rst cmd writes", 64'(wr_cnt[0] - w0), 64'(2));
        chk("post-rst cmd done", 64'(done_cnt[0] - d0), 64'(1));

        // Abort together with a valid third beat.
        w0 = wr_cnt[0]; d0 = done_cnt[0]; e0 = err_cnt[0];
        issue_cmd(0, 4'd1, 3'd4);
        send_beats(0, 2, 64'hB0, 1'b0);
        dat_valid[0] = 1'b1; dat_data[0] = 64'hB2; abort[0] = 1'b1;
        @(negedge clk);
        chk("abort dat_ready", 64'(dat_ready[0]), 64'(0));
        @(posedge clk); #1;
        abort[0] = 1'b0; dat_valid[0] = 1'b0;
        @(negedge clk);
        chk("abort err pulse", 64'(err[0]), 64'(1));
        chk("abort back idle", 64'(cmd_ready[0]), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("abort writes", 64'(wr_cnt[0] - w0), 64'(2));
        chk("abort done", 64'(done_cnt[0] - d0), 64'(0));
        chk("abort err count", 64'(err_cnt[0] - e0), 64'(1));

        // Paced burst with toggling source on the WR_GAP=2 instance.
        w0 = wr_cnt[1]; d0 = done_cnt[1];
        min_gap[1] = 1000;
        issue_cmd(1, 4'd5, 3'd3);
        send_beats(1, 3, 64'hD0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("pace writes", 64'(wr_cnt[1] - w0), 64'(3));
        chk("pace done", 64'(done_cnt[1] - d0), 64'(1));
        chk("pace spacing >= 3", 64'(min_gap[1] >= 3), 64'(1));

        // Random traffic on both instances, checked cycle by cycle by the model.
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 2; d++) begin
                cmd_valid[d]  = ($urandom_range(0, 3) == 0);
                cmd_sel[d]    = 4'($urandom);
                cmd_nwords[d] = ($urandom_range(0, 4) == 0) ? 3'($urandom) : 3'($urandom_range(1, 4));
                dat_valid[d]  = ($urandom_range(0, 2) != 0);
                dat_data[d]   = {$urandom, $urandom};
                abort[d]      = ($urandom_range(0, 19) == 0);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        abort[0] = 1'b1; abort[1] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0; abort[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("final idle d0", 64'(cmd_ready[0]), 64'(1));
        chk("final idle d1", 64'(cmd_ready[1]), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibf_cfg_write_loader.md
Name: ibf_cfg_write_loader

Overview:
- Write-side sequencer for the IBF parser config SRAM bank.
- Accepts configuration commands from the host/CSR path and splits each into a burst of 64-bit write beats on the bank's write port (sram_sel / wr_addr / wr_en / din).
- Sits directly upstream of the IBF config RAM write interface.
- Validates each command, paces the writes, and reports completion or error.

Parameters:
- NUM_SRAM, 16, number of valid sram_sel targets; a select value >= NUM_SRAM is illegal.
- MAX_WORDS, 4, maximum 64-bit words per command. Must be <= 4 because wr_addr is 2 bits.
- WR_GAP, 0, idle cycles inserted between consecutive write beats (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader can accept a command
- cmd_sel  in  4  target SRAM select
- cmd_nwords  in  3  number of words to write (legal range 1..MAX_WORDS)
- abort  in  1  cancel the burst in progress
- dat_valid  in  1  data beat present
- dat_ready  out  1  loader accepts a data beat
- dat_data  in  64  data beat
- sram_sel  out  4  to the config RAM write port
- wr_addr  out  2  word index within the entry
- wr_en  out  1  write strobe
- din  out  64  write data
- busy  out  1  a burst is in progress
- done  out  1  one-cycle pulse: burst completed
- err  out  1  one-cycle pulse: command rejected or burst aborted

Behaviour:
- Single clock domain. rst is asynchronous and active-high.
- Reset values: all outputs 0, except cmd_ready = 1 once rst deasserts. FSM goes to IDLE and all counters clear. Reset during a burst cancels it: no further wr_en, and no done or err pulse.
- sram_sel, wr_addr, wr_en, din, done and err are registered.
- FSM states: IDLE, DATA, GAP, DONE.
- IDLE:
  - cmd_ready = 1, dat_ready = 0, busy = 0.
  - On cmd_valid: if cmd_nwords == 0, or cmd_nwords > MAX_WORDS, or cmd_sel >= NUM_SRAM, then err = 1 in the next cycle, the FSM stays in IDLE and no write occurs.
  - Otherwise latch sel and nwords, clear the word counter cnt, and go to DATA.
- DATA:
  - dat_ready = !abort, busy = 1, cmd_ready = 0.
  - On a handshake (dat_valid & dat_ready), the next cycle drives wr_en = 1, din = dat_data, wr_addr = cnt, sram_sel = latched sel. Latency from handshake to write is exactly 1 cycle.
  - After the handshake, cnt increments.
  - If cnt == nwords-1 at the handshake, go to DONE.
  - Else if WR_GAP > 0, go to GAP.
  - Else stay in DATA, allowing back-to-back beats (one write per cycle).
- GAP:
  - dat_ready = 0, busy = 1.
  - Count WR_GAP cycles, then return to DATA.
- DONE:
  - Entered in the cycle the last wr_en is high. done = 1 in that same cycle. busy stays 1.
  - Next cycle: go to IDLE with cmd_ready = 1.
- wr_en is high only for one cycle per accepted beat.
- sram_sel, wr_addr and din hold their last values when wr_en = 0.
- abort:
  - Honoured in DATA or GAP. abort wins over a simultaneous dat_valid: the beat is not accepted and no write occurs.
  - Next cycle: err = 1 and the FSM returns to IDLE. Writes already issued are not rolled back.
  - abort in IDLE or DONE is ignored.
- dat_valid while dat_ready = 0 is not consumed; the source must hold the beat.
- cnt is 3 bits and never wraps, because nwords <= MAX_WORDS <= 4.
- A cmd_valid arriving while busy sees cmd_ready = 0 and is held off; no command is lost.

Test Plan:
- Reset mid-burst: sel = 2, nwords = 4; assert rst after 2 writes -> outputs 0 immediately, no further wr_en, no done or err; a fresh command afterwards works normally.
- Basic burst: cmd_sel = 3, cmd_nwords = 4, WR_GAP = 0, four consecutive beats 0xA0..0xA3 -> wr_en high for 4 consecutive cycles starting 1 cycle after the first handshake, wr_addr = 0,1,2,3, din = 0xA0..0xA3, sram_sel = 3; done coincides with the 4th write; cmd_ready returns the following cycle.
- Illegal commands: cmd_nwords = 0, then cmd_nwords = 5, then cmd_sel = 15 with NUM_SRAM = 8 -> one err pulse per command, zero wr_en, FSM stays in IDLE.
- Pacing and backpressure: WR_GAP = 2, nwords = 3, with dat_valid toggling -> writes spaced >= 3 cycles apart, dat_ready low during gaps, no beat dropped or duplicated.
- Abort: nwords = 4; after 2 writes, assert abort together with dat_valid -> the third beat is not written, err pulses next cycle, no done, IDLE is reached; exactly 2 wr_en pulses observed.
